multicycle_control: RTL and testbench

Main control FSM for the multicycle RV64 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and it generates the 2-bit `alu_op` consumed by the ALU control decoder (00 = add, 01 = subtract, 10 = decode funct fields). It handles R-type, `ld`, `sd` and `beq`, and stalls on a single memory-ready handshake.

---
 rtl/multicycle_control_pkg.sv | 100 ++++++++++
 rtl/multicycle_perf_counters.sv | 41 ++++
 rtl/multicycle_control.sv | 108 ++++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants, state encoding and per-state control decode for the multicycle RV64 control FSM.
// Optional performance counters are built only when MULTICYCLE_PERF_EN is defined.
package multicycle_control_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC   = 2'b00;
    localparam logic [1:0] SRC_A_RS1  = 2'b01;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExec,
        StAluWb,
        StBranch
    } state_e;

    // Purely state-decoded controls; pc_write/ir_write/illegal_op depend on inputs and live outside.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.iord      = 1'b0;
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_OP_ADD;
            end
            StDecode: begin
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            StMemAdr: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            StMemRd: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            StExec: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b0;
            end
            StBranch: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALU_OP_SUB;
                c.pc_src    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_perf_counters.sv
// Free-running cycle and retired-instruction counters; both wrap modulo 2^PERF_W.
// Instantiated by multicycle_control only when MULTICYCLE_PERF_EN is defined.
module multicycle_perf_counters #(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              active_i,
    input  logic              retire_i,
    output logic [PERF_W-1:0] cycle_cnt_o,
    output logic [PERF_W-1:0] instr_cnt_o
);

    logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [PERF_W-1:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (active_i) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (retire_i) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV64 datapath (R-type, ld, sd, beq) with a memory-ready stall.
// Define MULTICYCLE_PERF_EN to build the cycle/instruction performance counters.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ir_write,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              pc_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              illegal_op,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   illegal;

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LD, OP_SD: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            // IR is stable here, so re-decoding the opcode picks load vs store.
            StMemAdr: state_d = (opcode == OP_LD) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    // Controls are registered alongside the state so they are glitch-free for the whole state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;

    assign ir_write   = (state_q == StFetch) && mem_ready;
    assign pc_write   = ((state_q == StFetch) && mem_ready) || ((state_q == StBranch) && zero);
    assign illegal_op = illegal;

`ifdef MULTICYCLE_PERF_EN
    logic retire;

    assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBranch) ||
                    ((state_q == StMemWr) && mem_ready);

    multicycle_perf_counters #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .active_i   (state_q != StIdle),
        .retire_i   (retire),
        .cycle_cnt_o(cycle_cnt),
        .instr_cnt_o(instr_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle output signatures plus counter checks.
// Counter expectations follow MULTICYCLE_PERF_EN.
module tb_multicycle_control;

    localparam int unsigned PERF_W = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src,
    //  alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], illegal_op}
    localparam logic [14:0] S_IDLE    = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [14:0] S_FETCH   = 15'b1_1_0_1_0_0_0_0_00_01_00_0;
    localparam logic [14:0] S_FETCH_W = 15'b0_0_0_1_0_0_0_0_00_01_00_0;
    localparam logic [14:0] S_DECODE  = 15'b0_0_0_0_0_0_0_0_00_10_00_0;
    localparam logic [14:0] S_DEC_ILL = 15'b0_0_0_0_0_0_0_0_00_10_00_1;
    localparam logic [14:0] S_MEMADR  = 15'b0_0_0_0_0_0_0_0_01_10_00_0;
    localparam logic [14:0] S_MEMRD   = 15'b0_0_1_1_0_0_0_0_00_00_00_0;
    localparam logic [14:0] S_MEMWB   = 15'b0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [14:0] S_MEMWR   = 15'b0_0_1_0_1_0_0_0_00_00_00_0;
    localparam logic [14:0] S_EXEC    = 15'b0_0_0_0_0_0_0_0_01_00_10_0;
    localparam logic [14:0] S_ALUWB   = 15'b0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [14:0] S_BR_T    = 15'b1_0_0_0_0_0_0_1_01_00_01_0;
    localparam logic [14:0] S_BR_N    = 15'b0_0_0_0_0_0_0_1_01_00_01_0;

`ifdef MULTICYCLE_PERF_EN
    localparam logic [63:0] EXP_CYC_3R  = 64'd12;
    localparam logic [63:0] EXP_INS_3R  = 64'd3;
    localparam logic [63:0] EXP_INS_ILL = 64'd6;
`else
    localparam logic [63:0] EXP_CYC_3R  = 64'd0;
    localparam logic [63:0] EXP_INS_3R  = 64'd0;
    localparam logic [63:0] EXP_INS_ILL = 64'd0;
`endif

    logic              clk;
    logic              rst_n;
    logic [6:0]        opcode;
    logic              zero;
    logic              mem_ready;
    logic              pc_write, ir_write, iord, mem_read, mem_write;
    logic              reg_write, mem_to_reg, pc_src, illegal_op;
    logic [1:0]        alu_src_a, alu_src_b, alu_op;
    logic [PERF_W-1:0] cycle_cnt, instr_cnt;
    logic [14:0]       sig;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(
        .PERF_W(PERF_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .iord      (iord),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .illegal_op(illegal_op),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    assign sig = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src,
                  alu_src_a, alu_src_b, alu_op, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge: drive inputs, sample 1 ns later, advance one cycle.
    task automatic cyc(input string tag, input logic [6:0] op, input logic mr, input logic z,
                       input logic [14:0] exp);
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        #1;
        check(tag, {49'd0, sig}, {49'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {49'd0, sig}, 64'd0);
        check("reset_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
        check("reset_instr_cnt", {32'd0, instr_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three back-to-back R-type instructions, no stalls
        cyc("r_idle", OP_R, 1'b1, 1'b0, S_IDLE);
        for (int i = 0; i < 3; i++) begin
            cyc("r_fetch", OP_R, 1'b1, 1'b0, S_FETCH);
            cyc("r_decode", OP_R, 1'b0, 1'b0, S_DECODE);
            cyc("r_exec", OP_R, 1'b0, 1'b0, S_EXEC);
            cyc("r_aluwb", OP_R, 1'b0, 1'b0, S_ALUWB);
        end
        opcode    = OP_L;
        mem_ready = 1'b1;
        #1;
        check("cnt_cycle_3r", {32'd0, cycle_cnt}, EXP_CYC_3R);
        check("cnt_instr_3r", {32'd0, instr_cnt}, EXP_INS_3R);

        // ld with two wait cycles in MEMRD: 7 cycles total
        cyc("ld_fetch", OP_L, 1'b1, 1'b0, S_FETCH);
        cyc("ld_decode", OP_L, 1'b1, 1'b0, S_DECODE);
        cyc("ld_memadr", OP_L, 1'b1, 1'b0, S_MEMADR);
        cyc("ld_memrd_w0", OP_L, 1'b0, 1'b0, S_MEMRD);
        cyc("ld_memrd_w1", OP_L, 1'b0, 1'b0, S_MEMRD);
        cyc("ld_memrd_go", OP_L, 1'b1, 1'b0, S_MEMRD);
        cyc("ld_memwb", OP_L, 1'b1, 1'b0, S_MEMWB);

        // beq taken, then not taken (with a fetch stall)
        cyc("beq_t_fetch", OP_B, 1'b1, 1'b1, S_FETCH);
        cyc("beq_t_decode", OP_B, 1'b1, 1'b1, S_DECODE);
        cyc("beq_t_branch", OP_B, 1'b1, 1'b1, S_BR_T);
        cyc("beq_n_fetch_w", OP_B, 1'b0, 1'b0, S_FETCH_W);
        cyc("beq_n_fetch", OP_B, 1'b1, 1'b0, S_FETCH);
        cyc("beq_n_decode", OP_B, 1'b1, 1'b0, S_DECODE);
        cyc("beq_n_branch", OP_B, 1'b1, 1'b0, S_BR_N);

        // Illegal opcode: one-cycle pulse, back to FETCH, no retire
        cyc("ill_fetch", OP_BAD, 1'b1, 1'b0, S_FETCH);
        cyc("ill_decode", OP_BAD, 1'b1, 1'b0, S_DEC_ILL);
        opcode    = OP_S;
        mem_ready = 1'b1;
        #1;
        check("ill_instr_cnt", {32'd0, instr_cnt}, EXP_INS_ILL);

        // sd completing after one wait cycle
        cyc("sd_fetch", OP_S, 1'b1, 1'b0, S_FETCH);
        cyc("sd_decode", OP_S, 1'b1, 1'b0, S_DECODE);
        cyc("sd_memadr", OP_S, 1'b1, 1'b0, S_MEMADR);
        cyc("sd_memwr_w", OP_S, 1'b0, 1'b0, S_MEMWR);
        cyc("sd_memwr_go", OP_S, 1'b1, 1'b0, S_MEMWR);

        // Second sd, reset asserted mid-wait in MEMWR
        cyc("sd2_fetch", OP_S, 1'b1, 1'b0, S_FETCH);
        cyc("sd2_decode", OP_S, 1'b1, 1'b0, S_DECODE);
        cyc("sd2_memadr", OP_S, 1'b1, 1'b0, S_MEMADR);
        cyc("sd2_memwr_w", OP_S, 1'b0, 1'b0, S_MEMWR);
        mem_ready = 1'b0;
        #1;
        check("sd2_memwr_hold", {49'd0, sig}, {49'd0, S_MEMWR});
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_mid_outputs", {49'd0, sig}, 64'd0);
        check("rst_mid_cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst_idle", OP_R, 1'b1, 1'b0, S_IDLE);
        cyc("post_rst_fetch", OP_R, 1'b1, 1'b0, S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
